// File: rtl/arith_seq_ctrl.sv
// Multi-cycle wide add/sub/neg/inc sequencer over one shared N-bit slice.
// Optional Zero/Ovf flags when ARITH_SEQ_FLAGS_EN is defined.
module arith_seq_ctrl #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Start,
    input  logic               Abort,
    input  logic [1:0]         Sel,
    input  logic               Cin,
    input  logic [N*WORDS-1:0] A,
    input  logic [N*WORDS-1:0] B,
    output logic               Ready,
    output logic               Busy,
    output logic               Done,
    output logic [N*WORDS-1:0] Result,
    output logic               Cout
`ifdef ARITH_SEQ_FLAGS_EN
   ,output logic               Zero,
    output logic               Ovf
`endif
);

    localparam int W  = N * WORDS;
    localparam int CW = $clog2(WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;

    logic [1:0]    r_state;
    logic [1:0]    r_sel;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_result;
    logic          r_cout;

    logic [N-1:0]  w_x;
    logic [N-1:0]  w_y;
    logic [N:0]    w_full;
    logic          w_last;
    logic          w_first_c;

    // NEG/INC ignore A; SUB/NEG feed ~B with carry-in forced to 1
    assign w_x       = r_sel[1] ? '0 : r_a[N-1:0];
    assign w_y       = (r_sel[1] ^ r_sel[0]) ? ~r_b[N-1:0] : r_b[N-1:0];
    assign w_full    = {1'b0, w_x} + {1'b0, w_y} + {{N{1'b0}}, r_carry};
    assign w_last    = (r_cnt == CW'(WORDS - 1));
    assign w_first_c = (Sel == OP_ADD) ? Cin : 1'b1;

    assign Ready  = (r_state == S_IDLE);
    assign Busy   = (r_state == S_RUN);
    assign Done   = (r_state == S_DONE) & ~Abort;
    assign Result = r_result;
    assign Cout   = r_cout;

`ifdef ARITH_SEQ_FLAGS_EN
    logic r_nz;
    logic r_zero;
    logic r_ovf;
    logic w_c_msb;

    assign w_c_msb = w_x[N-1] ^ w_y[N-1] ^ w_full[N-1];
    assign Zero    = r_zero;
    assign Ovf     = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nz   <= 1'b0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (Start && !Abort)
                    r_nz <= 1'b0;
            end else if (Abort) begin
                r_zero <= 1'b0;
                r_ovf  <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_nz <= r_nz | (|w_full[N-1:0]);
                if (w_last) begin
                    r_zero <= ~(r_nz | (|w_full[N-1:0]));
                    r_ovf  <= w_c_msb ^ w_full[N];
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start && !Abort) begin
                        r_sel   <= Sel;
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= w_first_c;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (Abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        for (int k = 0; k < WORDS; k++) begin
                            if (r_cnt == CW'(k))
                                r_result[k*N +: N] <= w_full[N-1:0];
                        end
                        r_a     <= r_a >> N;
                        r_b     <= r_b >> N;
                        r_carry <= w_full[N];
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_cout  <= w_full[N];
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
